mem_arbiter: RTL

- Shares the single four-bank main memory between the instruction-cache controller and the data-cache controller. Each controller runs its own line-fill and write-back sequencing.
- Grants memory ownership for a whole line transaction, not per access. Muxes the owner's memory command onto the memory port and broadcasts read data back to both requesters.
- Sits between the two cache controllers and the memory.
- Uses round-robin priority. Inserts a drain gap so in-flight reads return before ownership changes.

---
 rtl/mem_arbiter_pkg.sv | 9 +
 rtl/arb_drain_cnt.sv | 19 +
 rtl/mem_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and defaults for the memory arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWN_I = 2'b01;
  localparam logic [1:0] ST_OWN_D = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;
  localparam int ADDR_W_DEF       = 16;
  localparam int DRAIN_CYCLES_DEF = 2;
endpackage

// File: rtl/arb_drain_cnt.sv
// arb_drain_cnt: loadable down-counter with zero flag, saturating at zero
module arb_drain_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin line-ownership arbiter between I- and D-cache controllers
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_data_in,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_data_in,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] mem_DataOut,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] i_mem_data,
  output logic [ADDR_W-1:0] d_mem_data,
  output logic              arb_err
);
  localparam int CW    = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam int LOADV = DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0;
  logic [1:0] state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       drop, zero, own_rd, own_wr;
  assign i_gnt = (state_q == ST_OWN_I);
  assign d_gnt = (state_q == ST_OWN_D);
  assign drop  = (i_gnt & ~i_req) | (d_gnt & ~d_req);
  // last_d_q set means D held the previous grant, so I wins the next tie
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (state_q == ST_IDLE)
      state_d = (i_req & d_req) ? (last_d_q ? ST_OWN_I : ST_OWN_D) :
                i_req ? ST_OWN_I : d_req ? ST_OWN_D : ST_IDLE;
    else if (drop) begin
      state_d  = (DRAIN_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
      last_d_d = d_gnt;
    end else if (state_q == ST_DRAIN && zero)
      state_d = ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end
  arb_drain_cnt #(.W(CW)) u_drain (
    .clk       (clk),
    .rst       (rst),
    .load_i    (drop),
    .load_val_i(CW'(LOADV)),
    .dec_i     (state_q == ST_DRAIN),
    .zero_o    (zero)
  );
  assign own_rd      = i_gnt ? i_rd : d_gnt ? d_rd : 1'b0;
  assign own_wr      = i_gnt ? i_wr : d_gnt ? d_wr : 1'b0;
  assign mem_rd      = own_rd & ~own_wr;
  assign mem_wr      = own_wr & ~own_rd;
  assign mem_addr    = i_gnt ? i_addr : d_gnt ? d_addr : '0;
  assign mem_data_in = i_gnt ? i_data_in : d_gnt ? d_data_in : '0;
  assign i_mem_data  = mem_DataOut;
  assign d_mem_data  = mem_DataOut;
  assign arb_err     = (~i_gnt & (i_rd | i_wr)) | (~d_gnt & (d_rd | d_wr)) | (own_rd & own_wr);
endmodule
